// File: rtl/flop_pkg.sv
// Field layout, FSM encoding and float struct for the 13-bit float {sign, mant[7:0], exp[3:0]},
// shared by the sequential divider and the combinational multiplier.
package flop_pkg;
    localparam int MANT_W   = 8;
    localparam int EXP_W    = 4;
    localparam int SIGN_BIT = 12;
    localparam int MANT_HI  = 11;
    localparam int MANT_LO  = 4;
    localparam int EXP_HI   = 3;
    localparam int EXP_LO   = 0;
    localparam logic [EXP_W-1:0] EXP_MAX = 4'hF;

    typedef struct packed {
        logic              sign;
        logic [MANT_W-1:0] mant;
        logic [EXP_W-1:0]  exp;
    } flop_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIVIDE,
        ST_NORM,
        ST_DONE
    } div_state_e;
endpackage

// File: rtl/flop_div_if.sv
// Start/busy/done handshake and operand/result bus of the float divider.
interface flop_div_if;
    logic        start;
    logic [12:0] one;
    logic [12:0] other;
    logic        busy;
    logic        done;
    logic [12:0] result;
    logic        div_by_zero;

    modport master (output start, one, other, input busy, done, result, div_by_zero);
    modport slave  (input start, one, other, output busy, done, result, div_by_zero);
endinterface

// File: rtl/flop_lzc16.sv
// 16-bit leading-one encoder: pos_o is the index of the highest set bit, vld_o flags a non-zero input.
module flop_lzc16 (
    input  logic [15:0] vec_i,
    output logic [3:0]  pos_o,
    output logic        vld_o
);
    always_comb begin
        pos_o = 4'd0;
        vld_o = 1'b0;
        // Ascending scan: the last hit is the most significant one.
        for (int i = 0; i < 16; i++) begin
            if (vec_i[i]) begin
                pos_o = 4'(i);
                vld_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/flop_div.sv
// Sequential restoring divider for the 13-bit float format (truncating, saturate/flush like the multiplier).
// Optional FLOP_DIV_EARLY_EXIT_EN: a zero mantissa operand skips DIVIDE/NORM and finishes right away.
module flop_div
    import flop_pkg::*;
(
    input logic       clk,
    input logic       reset_n,
    flop_div_if.slave bus
);
    div_state_e   state_q;
    logic         busy_q, done_q, dbz_q;
    logic [12:0]  result_q;
    logic [3:0]   cnt_q;

    flop_t        a_q, b_q;
    logic [7:0]   rem_q, rem_d;
    logic [15:0]  dvd_q, dvd_d;
    logic [3:0]   p_q;
    logic [8:0]   shl;
    logic         qbit;
    logic [3:0]   lzc_pos;
    logic         lzc_vld;
    logic         skip;
    flop_t        in_a, in_b, res_d;

    assign in_a = bus.one;
    assign in_b = bus.other;

`ifdef FLOP_DIV_EARLY_EXIT_EN
    assign skip = (in_a.mant == '0) || (in_b.mant == '0);
`else
    assign skip = 1'b0;
`endif

    function automatic flop_t pack_result(input flop_t a, input flop_t b,
                                          input logic [15:0] q, input logic [3:0] p);
        flop_t             r;
        logic signed [6:0] e;
        r.sign = (a.sign == b.sign);
        r.mant = 8'(({q, 7'b0}) >> p);
        e      = $signed({3'b000, a.exp}) - $signed({3'b000, b.exp})
               + $signed({3'b000, p}) - 7'sd7;
        r.exp  = e[3:0];
        if (b.mant == '0) begin
            r.mant = '0;
            r.exp  = EXP_MAX;
        end else if (a.mant == '0 || e < 7'sd0) begin
            r.mant = '0;
            r.exp  = '0;
        end else if (e > 7'sd15) begin
            r.mant = '0;
            r.exp  = EXP_MAX;
        end
        return r;
    endfunction

    // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
    always_comb begin
        shl = {rem_q, dvd_q[15]};
        qbit = (shl >= {1'b0, b_q.mant});
        rem_d = qbit ? 8'(shl - {1'b0, b_q.mant}) : shl[7:0];
        dvd_d = {dvd_q[14:0], qbit};
    end

    flop_lzc16 u_lzc (
        .vec_i (dvd_q),
        .pos_o (lzc_pos),
        .vld_o (lzc_vld)
    );

    assign res_d = pack_result(a_q, b_q, dvd_q, p_q);

    always_ff @(posedge clk) begin
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_q   <= in_a;
                    b_q   <= in_b;
                    rem_q <= '0;
                    dvd_q <= {in_a.mant, 8'h00};
                end
            end
            ST_DIVIDE: begin
                rem_q <= rem_d;
                dvd_q <= dvd_d;
            end
            ST_NORM: begin
                if (lzc_vld) p_q <= lzc_pos;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= 13'h000;
            cnt_q    <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        busy_q  <= 1'b1;
                        cnt_q   <= 4'd15;
                        state_q <= skip ? ST_DONE : ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd0) state_q <= ST_NORM;
                end
                ST_NORM: state_q <= ST_DONE;
                ST_DONE: begin
                    result_q <= res_d;
                    dbz_q    <= (b_q.mant == '0);
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_flop_div.sv
// Directed bench for flop_div: arithmetic reference model, per-cycle compare process, literal pins.
module tb_flop_div;
    logic clk = 1'b0;
    logic reset_n;
    int   n_pass = 0;
    int   n_total = 0;
    logic chk_en = 1'b0;

    flop_div_if bus();

    flop_div dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

`ifdef FLOP_DIV_EARLY_EXIT_EN
    localparam int LAT_Z = 1;
`else
    localparam int LAT_Z = 18;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: value = 0.mant * 2^exp, quotient truncated, returns {div_by_zero, result}.
    function automatic logic [13:0] model(input logic [12:0] x, input logic [12:0] y);
        int a, b, ea, eb, q, p, mant, e;
        logic s;
        a = int'(x[11:4]); b = int'(y[11:4]);
        ea = int'(x[3:0]); eb = int'(y[3:0]);
        s = (x[12] == y[12]);
        if (b == 0) return {1'b1, s, 8'h00, 4'hF};
        if (a == 0) return {1'b0, s, 12'h000};
        q = (a * 256) / b;
        p = 0;
        while ((q >> (p + 1)) != 0) p++;
        mant = (p >= 7) ? (q >> (p - 7)) : (q << (7 - p));
        e = ea - eb + p - 7;
        if (e < 0) return {1'b0, s, 12'h000};
        if (e > 15) return {1'b0, s, 8'h00, 4'hF};
        return {1'b0, s, mant[7:0], e[3:0]};
    endfunction

    // Timeline model: counts cycles from acceptance, ignores start while busy.
    logic        m_busy, m_done, m_dbz;
    logic [12:0] m_res;
    logic [13:0] m_pend;
    int          m_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0; m_res = 13'h000; m_cnt = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_res  = m_pend[12:0];
                    m_dbz  = m_pend[13];
                end
            end else if (bus.start) begin
                m_busy = 1'b1;
                m_pend = model(bus.one, bus.other);
                m_cnt  = (bus.one[11:4] == 8'h00 || bus.other[11:4] == 8'h00) ? LAT_Z : 18;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", bus.busy, m_busy);
            check("cyc_done", bus.done, m_done);
            check("cyc_result", bus.result, m_res);
            check("cyc_dbz", bus.div_by_zero, m_dbz);
        end
    end

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.done) break;
        end
    endtask

    task automatic do_op(input string name, input logic [12:0] x, input logic [12:0] y,
                         input logic [12:0] want_res, input logic want_dbz, input int want_lat);
        int lat;
        @(negedge clk);
        bus.one = x; bus.other = y; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        check({name, "_lat"}, lat, want_lat);
        check({name, "_res"}, bus.result, want_res);
        check({name, "_dbz"}, bus.div_by_zero, want_dbz);
    endtask

    initial begin
        int lat;
        int seen;
        reset_n = 1'b0;
        bus.start = 1'b0; bus.one = '0; bus.other = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_result", bus.result, 13'h000);
        check("rst_dbz", bus.div_by_zero, 1'b0);
        reset_n = 1'b1;
        chk_en = 1'b1;

        // Pin the reference model to hand-derived values.
        check("model_basic", model(13'h0805, 13'h0803), 14'h1803);
        check("model_sign", model(13'h1C04, 13'h0804), 14'h0C01);
        check("model_ovf", model(13'h0FFF, 13'h0800), 14'h100F);
        check("model_nonpow2", model(13'h0AA7, 13'h0332), 14'h1D57);

        do_op("basic", 13'h0805, 13'h0803, 13'h1803, 1'b0, 18);
        do_op("sign", 13'h1C04, 13'h0804, 13'h0C01, 1'b0, 18);
        do_op("udf", 13'h0800, 13'h0FFF, 13'h1000, 1'b0, 18);
        do_op("ovf", 13'h0FFF, 13'h0800, 13'h100F, 1'b0, 18);
        do_op("nonpow2", 13'h0AA7, 13'h0332, 13'h1D57, 1'b0, 18);
        do_op("small_q", 13'h101F, 13'h1FF0, 13'h1808, 1'b0, 18);
        do_op("divzero", 13'h0805, 13'h0003, 13'h100F, 1'b1, LAT_Z);
        do_op("zero_one", 13'h0005, 13'h0803, 13'h1000, 1'b0, LAT_Z);

        // Start mid-DIVIDE is ignored; start in the done cycle is accepted.
        @(negedge clk);
        bus.one = 13'h0805; bus.other = 13'h0803; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.one = 13'h0AA7; bus.other = 13'h0332; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        check("ignore_lat", lat, 18 - 6);
        check("ignore_res", bus.result, 13'h1803);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy", bus.busy, 1'b1);
        wait_done(lat);
        check("b2b_lat", lat, 18);
        check("b2b_res", bus.result, 13'h1D57);

        // Asynchronous reset in DIVIDE cycle 9 discards the operation.
        @(negedge clk);
        bus.one = 13'h0FFF; bus.other = 13'h0800; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 1'b0);
        check("arst_result", bus.result, 13'h000);
        check("arst_done", bus.done, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        check("arst_no_done", seen, 0);

        do_op("post_rst", 13'h0805, 13'h0803, 13'h1803, 1'b0, 18);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
